// File: rtl/controller_fsm_gen_pkg.sv
// -----------------------------------------------------------------------------
// controller_gen_pkg
// Shared types and constants for the second-generation CPU controller.
//   state_t          : FSM state encodings (also visible on the debug ports)
//   OP_*             : instruction opcodes
//   ALU_*            : ALUSelect codes driven to the datapath ALU
//   RF_SEL_*         : register-file write-source select codes
//   stateForOp()     : execute state reached from DECODE for a given opcode
//   isLegalOp()      : true for opcodes the controller implements
//   aluSelFor()      : ALUSelect code for an ALU-class opcode
// -----------------------------------------------------------------------------
package controller_gen_pkg;

  typedef enum logic [3:0] {
    INIT     = 4'b1000,
    FETCH    = 4'b1111,
    DECODE   = 4'b1100,
    NOOP     = 4'b0000,
    STORE    = 4'b0001,
    LOAD_REQ = 4'b0010,
    ALU      = 4'b0011,
    HALT     = 4'b0101,
    LOAD_WR  = 4'b0110,
    LDI      = 4'b0111,
    JMP      = 4'b1001,
    JPZ      = 4'b1010
  } state_t;

  localparam int unsigned OP_NOOP  = 0;
  localparam int unsigned OP_STORE = 1;
  localparam int unsigned OP_LOAD  = 2;
  localparam int unsigned OP_ADD   = 3;
  localparam int unsigned OP_SUB   = 4;
  localparam int unsigned OP_HALT  = 5;
  localparam int unsigned OP_LDI   = 6;
  localparam int unsigned OP_AND   = 7;
  localparam int unsigned OP_OR    = 8;
  localparam int unsigned OP_JMP   = 9;
  localparam int unsigned OP_JPZ   = 10;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;

  localparam logic [1:0] RF_SEL_ALU = 2'd0;
  localparam logic [1:0] RF_SEL_MEM = 2'd1;
  localparam logic [1:0] RF_SEL_IMM = 2'd2;

  // Everything above JPZ is unassigned and gets flagged as illegal.
  function automatic logic isLegalOp(input logic [31:0] opc);
    return (opc <= OP_JPZ);
  endfunction

  // Illegal opcodes fall back to FETCH so the CPU keeps running.
  function automatic state_t stateForOp(input logic [31:0] opc);
    case (opc)
      OP_NOOP:                         return NOOP;
      OP_STORE:                        return STORE;
      OP_LOAD:                         return LOAD_REQ;
      OP_ADD, OP_SUB, OP_AND, OP_OR:   return ALU;
      OP_HALT:                         return HALT;
      OP_LDI:                          return LDI;
      OP_JMP:                          return JMP;
      OP_JPZ:                          return JPZ;
      default:                         return FETCH;
    endcase
  endfunction

  function automatic logic [2:0] aluSelFor(input logic [31:0] opc);
    case (opc)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/controller_fsm_gen_if.sv
// -----------------------------------------------------------------------------
// controller_fsm_gen_if
// Bundle between the controller and the CPU datapath (IR/PC, register file,
// ALU, data memory).
//   master : controller side - drives the control outputs, reads status inputs
//   slave  : datapath side   - the mirror image
// Status inputs : instruction, IReady, DReady, RFAZero, Resume
// Control outs  : ALU/RF selects and addresses, data-memory request, PC and IR
//                 controls, Halted, IllegalOp, debug state outputs
// -----------------------------------------------------------------------------
interface controller_fsm_gen_if #(
  parameter int OPW = 4,
  parameter int DAW = 8,
  parameter int RAW = 4
);
  localparam int IW = OPW + DAW + RAW;

  logic [IW-1:0]  instruction;
  logic           IReady;
  logic           DReady;
  logic           RFAZero;
  logic           Resume;

  logic [2:0]     ALUSelect;
  logic [1:0]     RFSelect;
  logic [RAW-1:0] RFAReadAddr;
  logic [RAW-1:0] RFBReadAddr;
  logic [RAW-1:0] RFWriteAddr;
  logic           RFWriteEnable;
  logic [DAW-1:0] DAddr;
  logic           DReq;
  logic           DWrite;
  logic [DAW-1:0] Imm;
  logic           PCClr;
  logic           PCUp;
  logic           PCLd;
  logic [DAW-1:0] PCLdAddr;
  logic           IRLd;
  logic           Halted;
  logic           IllegalOp;
  logic [3:0]     CurrentStateOut;
  logic [3:0]     NextStateOut;

  modport master (
    input  instruction, IReady, DReady, RFAZero, Resume,
    output ALUSelect, RFSelect, RFAReadAddr, RFBReadAddr, RFWriteAddr,
           RFWriteEnable, DAddr, DReq, DWrite, Imm, PCClr, PCUp, PCLd,
           PCLdAddr, IRLd, Halted, IllegalOp, CurrentStateOut, NextStateOut
  );

  modport slave (
    output instruction, IReady, DReady, RFAZero, Resume,
    input  ALUSelect, RFSelect, RFAReadAddr, RFBReadAddr, RFWriteAddr,
           RFWriteEnable, DAddr, DReq, DWrite, Imm, PCClr, PCUp, PCLd,
           PCLdAddr, IRLd, Halted, IllegalOp, CurrentStateOut, NextStateOut
  );
endinterface

// File: rtl/controller_fsm_gen_field_decode.sv
// -----------------------------------------------------------------------------
// controller_field_decode
// Purely combinational split of the instruction word into its fields.
//   instr_i : instruction register contents (IW bits)
//   op_o    : opcode, top OPW bits
//   fA_o    : DAW-bit field right below the opcode (LOAD/LDI/JMP address/imm)
//   fB_o    : low DAW bits (STORE/JPZ address)
//   ra_o    : RAW bits right below the opcode
//   rb_o    : next RAW bits after ra
//   r0_o    : low RAW bits (destination register)
// -----------------------------------------------------------------------------
module controller_field_decode #(
  parameter int OPW = 4,
  parameter int DAW = 8,
  parameter int RAW = 4,
  parameter int IW  = OPW + DAW + RAW
) (
  input  logic [IW-1:0]  instr_i,
  output logic [OPW-1:0] op_o,
  output logic [DAW-1:0] fA_o,
  output logic [DAW-1:0] fB_o,
  output logic [RAW-1:0] ra_o,
  output logic [RAW-1:0] rb_o,
  output logic [RAW-1:0] r0_o
);

  // The fields overlap on purpose: which view is meaningful depends on the
  // opcode, and the controller picks the right one per state.
  assign op_o = instr_i[IW-1 -: OPW];
  assign fA_o = instr_i[IW-OPW-1 -: DAW];
  assign fB_o = instr_i[DAW-1:0];
  assign ra_o = instr_i[IW-OPW-1 -: RAW];
  assign rb_o = instr_i[IW-OPW-RAW-1 -: RAW];
  assign r0_o = instr_i[RAW-1:0];

endmodule

// File: rtl/controller_fsm_gen.sv
// -----------------------------------------------------------------------------
// controller_fsm_gen
// Second-generation controller for the 16-bit CPU datapath. Fetches with an
// IReady handshake, decodes, and sequences register file, ALU, data memory
// (DReady handshake) and PC. Supports NOOP, LOAD, STORE, ADD, SUB, AND, OR,
// LDI, JMP, JPZ and HALT/Resume; unknown opcodes set a sticky IllegalOp.
// Ports:
//   Clk : clock, rising edge
//   Rst : asynchronous active-low reset
//   bus : controller_fsm_gen_if.master - datapath status in, controls out
// Outputs are decoded combinationally from the current state (plus the
// handshake/zero inputs), so every control is zero unless a state asks for it.
// -----------------------------------------------------------------------------
module controller_fsm_gen
  import controller_gen_pkg::*;
#(
  parameter int OPW = 4,
  parameter int DAW = 8,
  parameter int RAW = 4
) (
  input logic                Clk,
  input logic                Rst,
  controller_fsm_gen_if.master bus
);

  localparam int IW = OPW + DAW + RAW;

  // ALU format packs ra and rb side by side inside the address field.
  generate
    if (2 * RAW > DAW) begin : gBadWidths
      $error("controller_fsm_gen: 2*RAW must not exceed DAW");
    end
  endgenerate

  state_t         state_q;
  state_t         state_d;
  logic           illegalOp_q;
  logic           illegalOp_d;

  logic [OPW-1:0] op;
  logic [DAW-1:0] fA;
  logic [DAW-1:0] fB;
  logic [RAW-1:0] ra;
  logic [RAW-1:0] rb;
  logic [RAW-1:0] r0;
  logic [31:0]    opCode;

  controller_field_decode #(
    .OPW (OPW),
    .DAW (DAW),
    .RAW (RAW),
    .IW  (IW)
  ) uFieldDecode (
    .instr_i (bus.instruction),
    .op_o    (op),
    .fA_o    (fA),
    .fB_o    (fB),
    .ra_o    (ra),
    .rb_o    (rb),
    .r0_o    (r0)
  );

  assign opCode = 32'(op);

  // State and the sticky illegal-opcode flag. Reset is asynchronous so that a
  // reset in the middle of a memory access drops DReq/DWrite immediately.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= INIT;
      illegalOp_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      illegalOp_q <= illegalOp_d;
    end
  end

  // Next-state and control decode. Every control starts at zero; each state
  // only raises what it needs. PCClr, PCUp and PCLd are raised in disjoint
  // states (INIT, FETCH, JMP/JPZ), so they can never collide.
  always_comb begin
    state_d           = state_q;
    illegalOp_d       = illegalOp_q;
    bus.ALUSelect     = ALU_PASS;
    bus.RFSelect      = RF_SEL_ALU;
    bus.RFAReadAddr   = '0;
    bus.RFBReadAddr   = '0;
    bus.RFWriteAddr   = '0;
    bus.RFWriteEnable = 1'b0;
    bus.DAddr         = '0;
    bus.DReq          = 1'b0;
    bus.DWrite        = 1'b0;
    bus.Imm           = '0;
    bus.PCClr         = 1'b0;
    bus.PCUp          = 1'b0;
    bus.PCLd          = 1'b0;
    bus.PCLdAddr      = '0;
    bus.IRLd          = 1'b0;
    bus.Halted        = 1'b0;

    case (state_q)
      INIT: begin
        bus.PCClr = 1'b1;
        state_d   = FETCH;
      end

      FETCH: begin
        if (bus.IReady) begin
          bus.PCUp = 1'b1;
          bus.IRLd = 1'b1;
          state_d  = DECODE;
        end
      end

      DECODE: begin
        state_d = stateForOp(opCode);
        if (!isLegalOp(opCode)) begin
          illegalOp_d = 1'b1;
        end
      end

      NOOP: begin
        state_d = FETCH;
      end

      // The address stays on DAddr through LOAD_WR so the memory data path
      // remains valid while the register file captures it.
      LOAD_REQ: begin
        bus.DAddr = fA;
        bus.DReq  = 1'b1;
        if (bus.DReady) begin
          state_d = LOAD_WR;
        end
      end

      LOAD_WR: begin
        bus.RFSelect      = RF_SEL_MEM;
        bus.RFWriteAddr   = r0;
        bus.RFWriteEnable = 1'b1;
        bus.DAddr         = fA;
        state_d           = FETCH;
      end

      // Leaving on the DReady cycle guarantees exactly one completed write.
      STORE: begin
        bus.DAddr       = fB;
        bus.RFAReadAddr = ra;
        bus.DReq        = 1'b1;
        bus.DWrite      = 1'b1;
        if (bus.DReady) begin
          state_d = FETCH;
        end
      end

      ALU: begin
        bus.RFAReadAddr   = ra;
        bus.RFBReadAddr   = rb;
        bus.RFWriteAddr   = r0;
        bus.ALUSelect     = aluSelFor(opCode);
        bus.RFSelect      = RF_SEL_ALU;
        bus.RFWriteEnable = 1'b1;
        state_d           = FETCH;
      end

      LDI: begin
        bus.Imm           = fA;
        bus.RFSelect      = RF_SEL_IMM;
        bus.RFWriteAddr   = r0;
        bus.RFWriteEnable = 1'b1;
        state_d           = FETCH;
      end

      JMP: begin
        bus.PCLd     = 1'b1;
        bus.PCLdAddr = fA;
        state_d      = FETCH;
      end

      // RFAZero reflects register ra in this same cycle.
      JPZ: begin
        bus.RFAReadAddr = ra;
        if (bus.RFAZero) begin
          bus.PCLd     = 1'b1;
          bus.PCLdAddr = fB;
        end
        state_d = FETCH;
      end

      HALT: begin
        bus.Halted = 1'b1;
        if (bus.Resume) begin
          state_d = FETCH;
        end
      end

      default: begin
        state_d = INIT;
      end
    endcase
  end

  assign bus.IllegalOp       = illegalOp_q;
  assign bus.CurrentStateOut = state_q;
  assign bus.NextStateOut    = state_d;

endmodule

// File: tb/tb_controller_fsm_gen.sv
// -----------------------------------------------------------------------------
// tb_controller_fsm_gen
// Self-checking bench for controller_fsm_gen. For each instruction the bench
// expands the instruction's behaviour into a per-cycle list of expected
// controls and inputs, then plays it against the DUT.
// -----------------------------------------------------------------------------
module tb_controller_fsm_gen;

  localparam logic [3:0] S_INIT     = 4'b1000;
  localparam logic [3:0] S_FETCH    = 4'b1111;
  localparam logic [3:0] S_DECODE   = 4'b1100;
  localparam logic [3:0] S_NOOP     = 4'b0000;
  localparam logic [3:0] S_STORE    = 4'b0001;
  localparam logic [3:0] S_LOAD_REQ = 4'b0010;
  localparam logic [3:0] S_ALU      = 4'b0011;
  localparam logic [3:0] S_HALT     = 4'b0101;
  localparam logic [3:0] S_LOAD_WR  = 4'b0110;
  localparam logic [3:0] S_LDI      = 4'b0111;
  localparam logic [3:0] S_JMP      = 4'b1001;
  localparam logic [3:0] S_JPZ      = 4'b1010;

  typedef struct {
    logic [15:0] instr;
    logic        iReady;
    logic        dReady;
    logic        zero;
    logic        resume;
    logic [3:0]  state;
    logic [3:0]  nextState;
    logic [2:0]  aluSel;
    logic [1:0]  rfSel;
    logic [3:0]  rfA;
    logic [3:0]  rfB;
    logic [3:0]  rfW;
    logic        rfWe;
    logic [7:0]  dAddr;
    logic        dReq;
    logic        dWrite;
    logic [7:0]  imm;
    logic        pcClr;
    logic        pcUp;
    logic        pcLd;
    logic [7:0]  pcLdAddr;
    logic        irLd;
    logic        halted;
    logic        illegal;
  } entry_t;

  logic   Clk;
  logic   Rst;
  entry_t trace[$];
  int     checks   = 0;
  int     errors   = 0;
  int     cycleNo  = 0;
  bit     modelIll = 1'b0;

  controller_fsm_gen_if #(.OPW(4), .DAW(8), .RAW(4)) bus ();

  controller_fsm_gen #(.OPW(4), .DAW(8), .RAW(4)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  // Free-running 10-unit clock.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Fresh cycle: every control expected low, don't-care inputs randomised.
  function automatic entry_t blankEntry(input logic [15:0] instr,
                                        input logic [3:0] st,
                                        input logic [3:0] nx);
    entry_t e;
    e.instr     = instr;
    e.iReady    = 1'($urandom);
    e.dReady    = 1'($urandom);
    e.zero      = 1'($urandom);
    e.resume    = 1'($urandom);
    e.state     = st;
    e.nextState = nx;
    e.aluSel    = 3'd0;
    e.rfSel     = 2'd0;
    e.rfA       = 4'd0;
    e.rfB       = 4'd0;
    e.rfW       = 4'd0;
    e.rfWe      = 1'b0;
    e.dAddr     = 8'd0;
    e.dReq      = 1'b0;
    e.dWrite    = 1'b0;
    e.imm       = 8'd0;
    e.pcClr     = 1'b0;
    e.pcUp      = 1'b0;
    e.pcLd      = 1'b0;
    e.pcLdAddr  = 8'd0;
    e.irLd      = 1'b0;
    e.halted    = 1'b0;
    e.illegal   = 1'b0;
    return e;
  endfunction

  task automatic pushEntry(input entry_t e);
    entry_t t;
    t         = e;
    t.illegal = modelIll;
    trace.push_back(t);
  endtask

  // Expand one instruction: iw fetch waits, dw memory waits, z = RFAZero for
  // JPZ, hw halted cycles before Resume.
  task automatic buildTrace(input logic [15:0] instr, input int iw,
                            input int dw, input bit z, input int hw);
    entry_t     e;
    logic [3:0] op;
    logic [7:0] fA;
    logic [7:0] fB;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] r0;
    logic [3:0] execSt;
    logic [2:0] aluCode;
    op = instr[15:12];
    fA = instr[11:4];
    fB = instr[7:0];
    ra = instr[11:8];
    rb = instr[7:4];
    r0 = instr[3:0];
    case (op)
      4'd0:                   execSt = S_NOOP;
      4'd1:                   execSt = S_STORE;
      4'd2:                   execSt = S_LOAD_REQ;
      4'd3, 4'd4, 4'd7, 4'd8: execSt = S_ALU;
      4'd5:                   execSt = S_HALT;
      4'd6:                   execSt = S_LDI;
      4'd9:                   execSt = S_JMP;
      4'd10:                  execSt = S_JPZ;
      default:                execSt = S_FETCH;
    endcase
    case (op)
      4'd3:    aluCode = 3'b001;
      4'd4:    aluCode = 3'b010;
      4'd7:    aluCode = 3'b011;
      default: aluCode = 3'b100;
    endcase

    for (int i = 0; i < iw; i++) begin
      e = blankEntry(instr, S_FETCH, S_FETCH);
      e.iReady = 1'b0;
      pushEntry(e);
    end
    e = blankEntry(instr, S_FETCH, S_DECODE);
    e.iReady = 1'b1; e.pcUp = 1'b1; e.irLd = 1'b1;
    pushEntry(e);
    e = blankEntry(instr, S_DECODE, execSt);
    pushEntry(e);
    if (op > 4'd10) modelIll = 1'b1;

    case (op)
      4'd0: pushEntry(blankEntry(instr, S_NOOP, S_FETCH));
      4'd1: begin
        for (int i = 0; i <= dw; i++) begin
          e = blankEntry(instr, S_STORE, (i == dw) ? S_FETCH : S_STORE);
          e.dReady = (i == dw);
          e.dAddr = fB; e.rfA = ra; e.dReq = 1'b1; e.dWrite = 1'b1;
          pushEntry(e);
        end
      end
      4'd2: begin
        for (int i = 0; i <= dw; i++) begin
          e = blankEntry(instr, S_LOAD_REQ, (i == dw) ? S_LOAD_WR : S_LOAD_REQ);
          e.dReady = (i == dw);
          e.dAddr = fA; e.dReq = 1'b1;
          pushEntry(e);
        end
        e = blankEntry(instr, S_LOAD_WR, S_FETCH);
        e.rfSel = 2'd1; e.rfW = r0; e.rfWe = 1'b1; e.dAddr = fA;
        pushEntry(e);
      end
      4'd3, 4'd4, 4'd7, 4'd8: begin
        e = blankEntry(instr, S_ALU, S_FETCH);
        e.rfA = ra; e.rfB = rb; e.rfW = r0; e.aluSel = aluCode; e.rfWe = 1'b1;
        pushEntry(e);
      end
      4'd5: begin
        for (int i = 0; i <= hw; i++) begin
          e = blankEntry(instr, S_HALT, (i == hw) ? S_FETCH : S_HALT);
          e.resume = (i == hw);
          e.halted = 1'b1;
          pushEntry(e);
        end
      end
      4'd6: begin
        e = blankEntry(instr, S_LDI, S_FETCH);
        e.imm = fA; e.rfSel = 2'd2; e.rfW = r0; e.rfWe = 1'b1;
        pushEntry(e);
      end
      4'd9: begin
        e = blankEntry(instr, S_JMP, S_FETCH);
        e.pcLd = 1'b1; e.pcLdAddr = fA;
        pushEntry(e);
      end
      4'd10: begin
        e = blankEntry(instr, S_JPZ, S_FETCH);
        e.zero = z; e.rfA = ra;
        if (z) begin
          e.pcLd = 1'b1; e.pcLdAddr = fB;
        end
        pushEntry(e);
      end
      default: ;
    endcase
  endtask

  task automatic applyStimulus(input entry_t e);
    bus.instruction = e.instr;
    bus.IReady      = e.iReady;
    bus.DReady      = e.dReady;
    bus.RFAZero     = e.zero;
    bus.Resume      = e.resume;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input entry_t e);
    string p;
    p = $sformatf("c%0d i%04h", cycleNo, e.instr);
    chk({p, " state"},     16'(bus.CurrentStateOut), 16'(e.state));
    chk({p, " next"},      16'(bus.NextStateOut),    16'(e.nextState));
    chk({p, " ALUSelect"}, 16'(bus.ALUSelect),       16'(e.aluSel));
    chk({p, " RFSelect"},  16'(bus.RFSelect),        16'(e.rfSel));
    chk({p, " RFA"},       16'(bus.RFAReadAddr),     16'(e.rfA));
    chk({p, " RFB"},       16'(bus.RFBReadAddr),     16'(e.rfB));
    chk({p, " RFW"},       16'(bus.RFWriteAddr),     16'(e.rfW));
    chk({p, " RFWE"},      16'(bus.RFWriteEnable),   16'(e.rfWe));
    chk({p, " DAddr"},     16'(bus.DAddr),           16'(e.dAddr));
    chk({p, " DReq"},      16'(bus.DReq),            16'(e.dReq));
    chk({p, " DWrite"},    16'(bus.DWrite),          16'(e.dWrite));
    chk({p, " Imm"},       16'(bus.Imm),             16'(e.imm));
    chk({p, " PCClr"},     16'(bus.PCClr),           16'(e.pcClr));
    chk({p, " PCUp"},      16'(bus.PCUp),            16'(e.pcUp));
    chk({p, " PCLd"},      16'(bus.PCLd),            16'(e.pcLd));
    chk({p, " PCLdAddr"},  16'(bus.PCLdAddr),        16'(e.pcLdAddr));
    chk({p, " IRLd"},      16'(bus.IRLd),            16'(e.irLd));
    chk({p, " Halted"},    16'(bus.Halted),          16'(e.halted));
    chk({p, " IllegalOp"}, 16'(bus.IllegalOp),       16'(e.illegal));
  endtask

  // Play up to n queued cycles: inputs 1 after the edge, outputs 2 after.
  task automatic runN(input int n);
    entry_t e;
    for (int i = 0; i < n && trace.size() > 0; i++) begin
      e = trace.pop_front();
      @(posedge Clk);
      #1 applyStimulus(e);
      #1 checkOutput(e);
      cycleNo++;
    end
  endtask

  task automatic runAll();
    runN(trace.size());
  endtask

  initial begin
    entry_t      e;
    logic [15:0] dirInstr [13];
    int          dirDw    [13];
    bit          dirZ     [13];
    int          dirHw    [13];

    dirInstr = '{16'h3125, 16'h4125, 16'h7125, 16'h8125, 16'h2A53, 16'h1340,
                 16'hA7C4, 16'hA7C4, 16'h9F00, 16'h6AB7, 16'h0000, 16'h5000,
                 16'hB000};
    dirDw    = '{0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0};
    dirZ     = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    dirHw    = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10, 0};

    Rst = 1'b1;
    applyStimulus(blankEntry(16'h0000, S_INIT, S_FETCH));
    #1 Rst = 1'b0;

    // Held in reset for two cycles: parked in INIT clearing the PC.
    for (int i = 0; i < 2; i++) begin
      @(posedge Clk);
      e = blankEntry(16'h0000, S_INIT, S_FETCH);
      e.pcClr = 1'b1;
      #1 applyStimulus(e);
      #1 checkOutput(e);
      cycleNo++;
    end

    @(posedge Clk);
    #1 Rst = 1'b1;
    e = blankEntry(16'h0000, S_INIT, S_FETCH);
    e.pcClr = 1'b1;
    applyStimulus(e);
    #1 checkOutput(e);
    cycleNo++;

    $display("[TB] directed instructions");
    for (int i = 0; i < 13; i++) begin
      buildTrace(dirInstr[i], 0, dirDw[i], dirZ[i], dirHw[i]);
      runAll();
    end
    // IllegalOp must stay set across later legal instructions.
    buildTrace(16'h3125, 2, 0, 1'b0, 0);
    runAll();

    $display("[TB] randomized instructions");
    for (int n = 0; n < 60; n++) begin
      buildTrace(16'($urandom), $urandom_range(0, 2), $urandom_range(0, 3),
                 1'($urandom), $urandom_range(0, 3));
      runAll();
    end

    $display("[TB] reset during STORE");
    buildTrace(16'h1340, 0, 3, 1'b0, 0);
    runN(3);
    trace.delete();
    modelIll = 1'b0;
    #1 Rst = 1'b0;
    e = blankEntry(16'h1340, S_INIT, S_FETCH);
    e.pcClr = 1'b1;
    #1 checkOutput(e);
    cycleNo++;
    @(posedge Clk);
    #1 Rst = 1'b1;
    applyStimulus(e);
    #1 checkOutput(e);
    cycleNo++;
    buildTrace(16'h7125, 1, 0, 1'b0, 0);
    runAll();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
